fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage directly upstream of the main decoder/controller. It holds the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake. It presents the instruction word to decode, then consumes decode's Jump (active-low) and Branch outputs to select the next PC when the datapath retires the instruction. Single-issue, non-pipelined: one instruction in flight.

Parameters:
ADDR_W, 32, PC and instruction-address width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_PC, 32'h0000_0080, PC loaded on misaligned target (only with FETCH_ALIGN_TRAP_EN).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
imem_req  out  1  fetch request; held until imem_ack.
imem_addr  out  ADDR_W  fetch address, equals pc while imem_req=1.
imem_ack  in  1  imem_rdata valid this cycle; ignored unless in FETCH.
imem_rdata  in  32  instruction word.
instr  out  32  latched instruction to decode.
instr_valid  out  1  instr valid, high in EXEC.
pc  out  ADDR_W  address of current instruction.
pc_plus4  out  ADDR_W  pc+4 (link value for jal; branch base).
jump_n  in  1  from decode: 0 = take jump (j/jal/jr), 1 = no jump.
branch  in  1  from decode: 1 = take branch (already qualified by zero).
rs_data  in  ADDR_W  register rs value, used as jr target.
retire  in  1  datapath done with instr; sampled only in EXEC.
trap  out  1  one-cycle pulse on misaligned target (feature only; tie 0 otherwise).

Behaviour:
- Async reset: state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, trap=0. Reset mid-fetch drops imem_req immediately; any later imem_ack is ignored.
- States: IDLE -> FETCH -> EXEC -> FETCH ... (TRAP with feature).
- IDLE: one cycle after reset deassertion, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, go to EXEC. Minimum latency from FETCH entry to instr_valid = 1 cycle (ack in first FETCH cycle).
- EXEC: instr_valid=1, instr and pc stable. jump_n, branch, rs_data are sampled only on the cycle retire=1. On retire: pc<=next_pc, go to FETCH the next cycle. Without retire, hold indefinitely.
- next_pc priority:
  1. jump_n=0 and instr is jr (op=6'b000000, func=6'b001000): rs_data.
  2. jump_n=0 otherwise (j/jal): {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. branch=1: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  4. Otherwise: pc_plus4.
  jump_n=0 and branch=1 together: jump wins.
- Arithmetic is modulo 2^ADDR_W. pc=32'hFFFF_FFFC sequential gives 32'h0000_0000. Negative offsets wrap the same way.
- pc_plus4 is combinational from pc and always valid.
- Without the feature, misaligned targets (bits[1:0]≠0) load unchanged. imem_addr carries them as-is.
- Inputs outside EXEC, and imem_ack outside FETCH, have no effect.

Optional Feature:
FETCH_ALIGN_TRAP_EN:
- Defined: on retire, if next_pc[1:0]≠2'b00, pc<=TRAP_PC and trap=1 for exactly one cycle (the TRAP state), then FETCH. No fetch is issued to the misaligned address.
- Undefined: no TRAP state, trap tied 0, misaligned address fetched as-is.

Decomposition:
- Shared package: fetch state encoding (IDLE, FETCH, EXEC, TRAP), opcode/func constants (OP_RTYPE=6'b000000, FUNC_JR=6'b001000, OP_J=6'b000010, OP_JAL=6'b000011), RESET_PC default.
- One sub-module, fetch_next_pc: purely combinational next-PC selection/adder (pc, instr, jump_n, branch, rs_data -> next_pc). Unit-testable alone.

Test Plan:
- Reset then imem_ack with rdata=32'h2008_0005 in first FETCH cycle -> imem_addr=0, instr_valid next cycle, instr=32'h2008_0005. Retire with jump_n=1, branch=0 -> next fetch at 32'h4.
- EXEC at pc=32'h0000_0010, instr beq with imm=16'hFFFC, branch=1 on retire -> next imem_addr=32'h0000_0004. With imm=16'h0003 -> 32'h0000_0020.
- pc=32'h1000_0000, instr j with target field 26'h000_0040, jump_n=0 -> 32'h1000_0100. jr with rs_data=32'h0000_0200, jump_n=0, branch=1 -> 32'h0000_0200 (jump priority).
- Hold imem_ack low 5 cycles -> imem_req stays 1, addr stable. Assert rst in 3rd cycle -> imem_req=0 immediately. Stray ack after reset -> instr stays 0.
- pc=32'hFFFF_FFFC, sequential retire -> next fetch at 32'h0. Retire held low 10 cycles in EXEC -> instr/pc unchanged.
- FETCH_ALIGN_TRAP_EN: jr with rs_data=32'h0000_0102 -> trap pulses 1 cycle, next fetch at TRAP_PC=32'h80. Without macro -> fetch at 32'h0000_0102, trap=0.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared fetch state encoding, opcode constants and reset defaults
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FUNC_JR  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEFAULT  = 32'h0000_0080;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC select: jr, j/jal, branch, sequential
module fetch_next_pc
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    input  logic              jump_n_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] rs_data_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic              is_jr;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;

    assign pc_plus4_o = pc_i + ADDR_W'(4);
    assign is_jr      = (instr_i[31:26] == OP_RTYPE) && (instr_i[5:0] == FUNC_JR);
    // Word offset, sign-extended then scaled by 4; wraps modulo 2^ADDR_W
    assign br_off     = {{(ADDR_W-18){instr_i[15]}}, instr_i[15:0], 2'b00};
    // Pseudo-direct target keeps the region bits of the sequential PC
    assign jmp_tgt    = {pc_plus4_o[ADDR_W-1:28], instr_i[25:0], 2'b00};

    // Jump beats branch; jr takes its target from the register file
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (!jump_n_i && is_jr) begin
            next_pc_o = rs_data_i;
        end else if (!jump_n_i) begin
            next_pc_o = jmp_tgt;
        end else if (branch_i) begin
            next_pc_o = pc_plus4_o + br_off;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - single-issue fetch stage; optional misaligned-target trap via FETCH_ALIGN_TRAP_EN
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] TRAP_PC  = TRAP_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump_n,
    input  logic              branch,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              retire,
    output logic              trap
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic              imem_req_q;
    logic [ADDR_W-1:0] next_pc_d;

    fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_i       (pc_q),
        .instr_i    (instr_q),
        .jump_n_i   (jump_n),
        .branch_i   (branch),
        .rs_data_i  (rs_data),
        .pc_plus4_o (pc_plus4),
        .next_pc_o  (next_pc_d)
    );

    // The fetch address is the PC itself; only imem_req qualifies it
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign imem_req    = imem_req_q;

`ifdef FETCH_ALIGN_TRAP_EN
    logic trap_q;
    assign trap = trap_q;

    // Fetch FSM with registered outputs; misaligned targets detour through TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        instr_valid_q <= 1'b0;
                        if (next_pc_d[1:0] != 2'b00) begin
                            pc_q    <= TRAP_PC;
                            trap_q  <= 1'b1;
                            state_q <= ST_TRAP;
                        end else begin
                            pc_q       <= next_pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    trap_q     <= 1'b0;
                    imem_req_q <= 1'b1;
                    state_q    <= ST_FETCH;
                end
            endcase
        end
    end
`else
    assign trap = 1'b0;

    // Fetch FSM with registered outputs; any target, aligned or not, is fetched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= next_pc_d;
                        imem_req_q    <= 1'b1;
                        state_q       <= ST_FETCH;
                    end
                end
                default: begin
                    imem_req_q <= 1'b1;
                    state_q    <= ST_FETCH;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit with directed vectors
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump_n = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic        retire = 1'b0;
    logic        trap;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] I_ADDI  = 32'h2008_0005;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_BEQ_N = 32'h1000_FFFC;
    localparam logic [31:0] I_BEQ_P = 32'h1000_0003;
    localparam logic [31:0] I_J     = {OP_J, 26'h000_0040};

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .jump_n      (jump_n),
        .branch      (branch),
        .rs_data     (rs_data),
        .retire      (retire),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch is matched against the expected address queue
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_fetch: got %h expected none", imem_addr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (imem_addr !== e) begin
                    failures++;
                    $display("FAIL sb_fetch_addr: got %h expected %h", imem_addr, e);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        int n;
        exp_q.push_back(addr);
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            failures++;
            checks++;
            $display("FAIL fetch_timeout: got req=0 expected req=1");
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        check("instr_valid", {31'h0, instr_valid}, 32'h1);
        check("instr", instr, data);
    endtask

    task automatic do_retire(input logic jn, input logic br, input logic [31:0] rs);
        jump_n  = jn;
        branch  = br;
        rs_data = rs;
        retire  = 1'b1;
        tick();
        retire  = 1'b0;
        jump_n  = 1'b1;
        branch  = 1'b0;
        rs_data = 32'hA5A5_A5A5;
    endtask

    initial begin
        logic [31:0] stall_addr;
        tick();
        tick();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_trap", {31'h0, trap}, 32'h0);
        rst = 1'b0;
        tick();
        check("first_req", {31'h0, imem_req}, 32'h1);
        fetch(32'h0, I_ADDI);
        check("pc_plus4", pc_plus4, 32'h4);
        do_retire(1'b1, 1'b0, 32'h0);
        fetch(32'h4, I_JR);
        do_retire(1'b0, 1'b0, 32'h10);
        fetch(32'h10, I_BEQ_N);
        do_retire(1'b1, 1'b1, 32'h0);
        fetch(32'h4, I_JR);
        do_retire(1'b0, 1'b0, 32'h10);
        fetch(32'h10, I_BEQ_P);
        do_retire(1'b1, 1'b1, 32'h0);
        fetch(32'h20, I_JR);
        do_retire(1'b0, 1'b0, 32'h1000_0000);
        fetch(32'h1000_0000, I_J);
        do_retire(1'b0, 1'b0, 32'h0);
        fetch(32'h1000_0100, I_JR);
        do_retire(1'b0, 1'b1, 32'h200);
        fetch(32'h200, I_JR);
        do_retire(1'b0, 1'b0, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, I_ADDI);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        // Inputs without retire must not disturb EXEC
        jump_n = 1'b0;
        branch = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        jump_n = 1'b1;
        branch = 1'b0;
        check("hold_instr", instr, I_ADDI);
        check("hold_pc", pc, 32'hFFFF_FFFC);
        check("hold_valid", {31'h0, instr_valid}, 32'h1);
        do_retire(1'b1, 1'b0, 32'h0);
        fetch(32'h0, I_JR);
        do_retire(1'b0, 1'b0, 32'h0000_0102);
`ifdef FETCH_ALIGN_TRAP_EN
        check("trap_pulse", {31'h0, trap}, 32'h1);
        check("trap_no_req", {31'h0, imem_req}, 32'h0);
        check("trap_pc", pc, 32'h80);
        tick();
        check("trap_clear", {31'h0, trap}, 32'h0);
        stall_addr = 32'h80;
`else
        check("no_trap", {31'h0, trap}, 32'h0);
        stall_addr = 32'h0000_0102;
`endif
        check("stall_req", {31'h0, imem_req}, 32'h1);
        check("stall_addr", imem_addr, stall_addr);
        tick();
        tick();
        check("stall_req2", {31'h0, imem_req}, 32'h1);
        check("stall_addr2", imem_addr, stall_addr);
        rst = 1'b1;
        #1;
        check("rst_drop_req", {31'h0, imem_req}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("stray_instr", instr, 32'h0);
        check("stray_valid", {31'h0, instr_valid}, 32'h0);
        check("sb_drained", exp_q.size(), 32'h0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
